// File: rtl/ddr_readout_pkg.sv
// Shared state encoding, default parameter values and a saturating
// subtract helper for the DDR readout controller.
package ddr_readout_pkg;

    typedef enum logic [2:0] {
        RST_FIFO = 3'd0,
        WAIT_RST = 3'd1,
        IDLE     = 3'd2,
        REQ      = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    localparam int DEF_DATA_W      = 256;
    localparam int DEF_ADDR_W      = 29;
    localparam int DEF_BURST_BYTES = 32;
    localparam int DEF_ADDR_INC    = 8;
    localparam int DEF_OBCNT_W     = 9;
    localparam int DEF_OB_THRESH   = 200;
    localparam int DEF_OST_W       = 10;
    localparam int DEF_RST_CYC     = 4;

    // The last burst may be shorter than BURST_BYTES; clamp instead of wrapping.
    function automatic logic [31:0] sat_dec(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/readout_ost_counter.sv
// Counts accepted-but-unreturned read commands and flags data returning with none outstanding.
// Count and error register one cycle after the event; o_count_nxt is the combinational next value.
module readout_ost_counter
    import ddr_readout_pkg::*;
#(
    parameter int OST_W = DEF_OST_W
) (
    input  logic             clk,
    input  logic             reset_clk,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [OST_W-1:0] o_count,
    output logic [OST_W-1:0] o_count_nxt,
    output logic             o_err
);

    localparam logic [OST_W-1:0] ONE = OST_W'(1);

    logic [OST_W-1:0] r_count;
    logic             r_err;
    logic [OST_W-1:0] w_nxt;
    logic             w_underflow;

    // Simultaneous issue and return cancel out.
    always_comb begin
        w_nxt       = r_count;
        w_underflow = 1'b0;
        if (i_inc && !i_dec) begin
            w_nxt = r_count + ONE;
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                w_underflow = 1'b1;
            end else begin
                w_nxt = r_count - ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_nxt;
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_count     = r_count;
    assign o_count_nxt = w_nxt;
    assign o_err       = r_err;

endmodule

// File: rtl/ddr_readout_ctrl.sv
// Streams a byte range from DDR into an output buffer as credit-limited burst reads.
// Read data reaches the buffer one cycle later; commands hold until acked and stall on buffer credit.
module ddr_readout_ctrl
    import ddr_readout_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int BURST_BYTES = DEF_BURST_BYTES,
    parameter int ADDR_INC    = DEF_ADDR_INC,
    parameter int OBCNT_W     = DEF_OBCNT_W,
    parameter int OB_THRESH   = DEF_OB_THRESH,
    parameter int OST_W       = DEF_OST_W,
    parameter int RST_CYC     = DEF_RST_CYC
) (
    input  logic              clk,
    input  logic              reset_clk,
    input  logic              readout_start,
    input  logic              readout_done,
    input  logic [ADDR_W-1:0] readout_addr,
    input  logic [31:0]       readout_count,
    input  logic              wrap_en,
    input  logic [ADDR_W-1:0] ring_base,
    input  logic [ADDR_W-1:0] ring_limit,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_data_valid,
    output logic              ob_wr_en,
    output logic [DATA_W-1:0] ob_din,
    input  logic [OBCNT_W-1:0] ob_count,
    output logic              ob_rst,
    input  logic              ob_wr_rst_busy,
    input  logic              ob_rd_rst_busy,
    output logic              busy,
    output logic              done,
    output logic [OST_W-1:0]  outstanding,
    output logic              err_overrun
);

    localparam int                RCNT_W   = $clog2(RST_CYC + 1);
    localparam logic [RCNT_W-1:0] RST_LAST = RCNT_W'(RST_CYC - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE = RCNT_W'(1);
    localparam logic [ADDR_W-1:0] INC      = ADDR_W'(ADDR_INC);
    localparam logic [31:0]       THRESH   = 32'(OB_THRESH);
    localparam logic [31:0]       BURST    = 32'(BURST_BYTES);

    state_t              r_state;
    logic [RCNT_W-1:0]   r_rst_cnt;
    logic                r_ob_rst;
    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_remaining;
    logic                r_ob_wr_en;
    logic [DATA_W-1:0]   r_ob_din;
    logic                r_busy;
    logic                r_done;

    logic                w_hs;
    logic [OST_W-1:0]    w_ost;
    logic [OST_W-1:0]    w_ost_nxt;
    logic                w_err;
    logic [31:0]         w_fill;
    logic                w_credit_ok;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [31:0]         w_rem_dec;
    logic                w_flushing;

    readout_ost_counter #(
        .OST_W (OST_W)
    ) u_ost (
        .clk         (clk),
        .reset_clk   (reset_clk),
        .i_inc       (w_hs),
        .i_dec       (mem_rd_data_valid),
        .o_count     (w_ost),
        .o_count_nxt (w_ost_nxt),
        .o_err       (w_err)
    );

    assign w_hs = r_req && mem_rd_ack;

    // Credit uses next-cycle outstanding so a back-to-back issue never overshoots the limit.
    assign w_fill      = 32'(ob_count) + 32'(w_ost_nxt);
    assign w_credit_ok = (w_fill < THRESH);

    assign w_addr_inc  = r_addr + INC;
    assign w_addr_next = (wrap_en && (w_addr_inc >= ring_limit)) ? ring_base : w_addr_inc;
    assign w_rem_dec   = sat_dec(r_remaining, BURST);
    assign w_flushing  = (r_state == RST_FIFO) || (r_state == WAIT_RST);

    always_ff @(posedge clk or posedge reset_clk) begin
        if (reset_clk) begin
            r_state     <= RST_FIFO;
            r_rst_cnt   <= '0;
            r_ob_rst    <= 1'b1;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_ob_wr_en  <= 1'b0;
            r_ob_din    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_ob_wr_en <= mem_rd_data_valid && !w_flushing;
            r_ob_din   <= mem_rd_data;

            // An accepted command always drops; REQ re-raises it when another burst may go.
            if (w_hs) begin
                r_req <= 1'b0;
            end

            if (readout_done) begin
                r_state     <= RST_FIFO;
                r_rst_cnt   <= '0;
                r_ob_rst    <= 1'b1;
                r_busy      <= 1'b0;
                r_remaining <= '0;
            end else begin
                case (r_state)
                    RST_FIFO: begin
                        if (r_rst_cnt == RST_LAST) begin
                            r_state  <= WAIT_RST;
                            r_ob_rst <= 1'b0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + RCNT_ONE;
                        end
                    end

                    // A still-pending command would otherwise leak into the next transfer.
                    WAIT_RST: begin
                        if (!ob_wr_rst_busy && !ob_rd_rst_busy && (w_ost == '0) && !r_req) begin
                            r_state <= IDLE;
                        end
                    end

                    IDLE: begin
                        if (readout_start) begin
                            if (readout_count == 32'd0) begin
                                r_done <= 1'b1;
                            end else begin
                                r_addr      <= readout_addr;
                                r_remaining <= readout_count;
                                r_busy      <= 1'b1;
                                r_state     <= REQ;
                            end
                        end
                    end

                    REQ: begin
                        if (w_hs) begin
                            r_addr      <= w_addr_next;
                            r_remaining <= w_rem_dec;
                            if (w_rem_dec == 32'd0) begin
                                r_state <= DRAIN;
                            end else if (w_credit_ok) begin
                                r_req <= 1'b1;
                            end
                        end else if (!r_req && (r_remaining != 32'd0) && w_credit_ok) begin
                            r_req <= 1'b1;
                        end
                    end

                    DRAIN: begin
                        if (w_ost == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end

                    default: begin
                        r_state <= RST_FIFO;
                    end
                endcase
            end
        end
    end

    assign mem_rd_req  = r_req;
    assign mem_rd_addr = r_addr;
    assign ob_wr_en    = r_ob_wr_en;
    assign ob_din      = r_ob_din;
    assign ob_rst      = r_ob_rst;
    assign busy        = r_busy;
    assign done        = r_done;
    assign outstanding = w_ost;
    assign err_overrun = w_err;

endmodule

// File: tb/tb_ddr_readout_ctrl.sv
// Directed bench for ddr_readout_ctrl: a memory responder plus a transaction-level
// model of buffer writes, outstanding count and the sticky error, checked every cycle.
module tb_ddr_readout_ctrl;

    localparam int DATA_W  = 256;
    localparam int ADDR_W  = 29;
    localparam int OBCNT_W = 9;
    localparam int OST_W   = 10;
    localparam int RD_LAT  = 3;

    logic              clk = 1'b0;
    logic              reset_clk;
    logic              readout_start;
    logic              readout_done;
    logic [ADDR_W-1:0] readout_addr;
    logic [31:0]       readout_count;
    logic              wrap_en;
    logic [ADDR_W-1:0] ring_base;
    logic [ADDR_W-1:0] ring_limit;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_ack = 1'b0;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              mem_rd_data_valid = 1'b0;
    logic              ob_wr_en;
    logic [DATA_W-1:0] ob_din;
    logic [OBCNT_W-1:0] ob_count;
    logic              ob_rst;
    logic              ob_wr_rst_busy;
    logic              ob_rd_rst_busy;
    logic              busy;
    logic              done;
    logic [OST_W-1:0]  outstanding;
    logic              err_overrun;

    ddr_readout_ctrl dut (
        .clk               (clk),
        .reset_clk         (reset_clk),
        .readout_start     (readout_start),
        .readout_done      (readout_done),
        .readout_addr      (readout_addr),
        .readout_count     (readout_count),
        .wrap_en           (wrap_en),
        .ring_base         (ring_base),
        .ring_limit        (ring_limit),
        .mem_rd_req        (mem_rd_req),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_ack        (mem_rd_ack),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_data_valid (mem_rd_data_valid),
        .ob_wr_en          (ob_wr_en),
        .ob_din            (ob_din),
        .ob_count          (ob_count),
        .ob_rst            (ob_rst),
        .ob_wr_rst_busy    (ob_wr_rst_busy),
        .ob_rd_rst_busy    (ob_rd_rst_busy),
        .busy              (busy),
        .done              (done),
        .outstanding       (outstanding),
        .err_overrun       (err_overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Written only by the main sequence.
    bit return_en;
    bit ack_en;
    bit flushing;
    int stray_req;

    // Written only by the memory/model process.
    int                cyc = 0;
    int                stray_done = 0;
    logic [ADDR_W-1:0] pend_addr[$];
    int                pend_due[$];
    logic [ADDR_W-1:0] iss_q[$];
    int                m_ost = 0;
    bit                m_err = 1'b0;
    bit                prev_valid = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    bit                prev_req = 1'b0;
    bit                prev_hs = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    bit                prev_done = 1'b0;
    int                flush_age = 0;
    int                done_cnt = 0;
    int                done_cyc = 0;
    int                last_beat_cyc = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] fdat(input logic [ADDR_W-1:0] a);
        return {8{32'(a) ^ 32'hA5A5_0000}};
    endfunction

    // Memory responder and reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        bit hs;
        bit v;
        cyc++;

        chk("ob_wr_en", ob_wr_en, prev_valid && !flushing);
        if (prev_valid && !flushing) chk("ob_din", ob_din, prev_data);
        chk("outstanding", outstanding, m_ost);
        chk("err_overrun", err_overrun, m_err);
        if (prev_req && !prev_hs) begin
            chk("req_hold", mem_rd_req, 1'b1);
            chk("addr_hold", mem_rd_addr, prev_addr);
        end
        if (flushing && flush_age >= 1) chk("no_new_req_in_flush", mem_rd_req && (!prev_req || prev_hs), 1'b0);
        if (done) begin
            chk("done_one_cycle", prev_done, 1'b0);
            done_cnt++;
            done_cyc = cyc;
        end
        prev_done = done;

        mem_rd_ack = ack_en;
        hs = mem_rd_req && ack_en;
        if (hs) begin
            iss_q.push_back(mem_rd_addr);
            pend_addr.push_back(mem_rd_addr);
            pend_due.push_back(cyc + RD_LAT);
        end
        v = 1'b0;
        if (stray_req != stray_done) begin
            v = 1'b1;
            mem_rd_data = fdat('1);
            stray_done++;
        end else if (return_en && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            v = 1'b1;
            mem_rd_data = fdat(pend_addr.pop_front());
            void'(pend_due.pop_front());
            last_beat_cyc = cyc;
        end
        mem_rd_data_valid = v;

        if (hs && !v) m_ost++;
        else if (v && !hs) begin
            if (m_ost == 0) m_err = 1'b1;
            else m_ost--;
        end
        prev_valid = v;
        prev_data  = mem_rd_data;
        prev_req   = mem_rd_req;
        prev_hs    = hs;
        prev_addr  = mem_rd_addr;
        if (flushing) flush_age++;
        else flush_age = 0;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_xfer(input logic [ADDR_W-1:0] a, input logic [31:0] n);
        readout_addr  = a;
        readout_count = n;
        readout_start = 1'b1;
        @(posedge clk);
        #2;
        readout_start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
    endtask

    task automatic chk_addrs(input string nm, input int n,
                             input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                             input logic [ADDR_W-1:0] a2);
        chk({nm, "_nreq"}, iss_q.size(), n);
        for (int i = 0; i < n && i < iss_q.size(); i++)
            chk($sformatf("%s_addr%0d", nm, i), iss_q[i], (i == 0) ? a0 : (i == 1) ? a1 : a2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int rst_hi;
        reset_clk      = 1'b1;
        readout_start  = 1'b0;
        readout_done   = 1'b0;
        readout_addr   = '0;
        readout_count  = '0;
        wrap_en        = 1'b0;
        ring_base      = '0;
        ring_limit     = '0;
        ob_count       = '0;
        ob_wr_rst_busy = 1'b1;
        ob_rd_rst_busy = 1'b1;
        return_en      = 1'b1;
        ack_en         = 1'b1;
        flushing       = 1'b1;
        stray_req      = 0;

        // Reset state and buffer-reset pulse length.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ob_rst", ob_rst, 1'b1);
        chk("rst_req", mem_rd_req, 1'b0);
        chk("rst_addr", mem_rd_addr, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ob_din", ob_din, 0);
        @(posedge clk);
        #2;
        reset_clk = 1'b0;
        rst_hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ob_rst) rst_hi++;
            @(posedge clk);
            #2;
            if (i == 2) begin
                ob_wr_rst_busy = 1'b0;
                ob_rd_rst_busy = 1'b0;
            end
        end
        chk("ob_rst_cycles", rst_hi, 4);
        chk("idle_busy", busy, 1'b0);
        flushing = 1'b0;

        // Three full bursts, ack every cycle.
        d0 = done_cnt;
        iss_q.delete();
        start_xfer(29'h100, 32'd96);
        chk("t1_busy", busy, 1'b1);
        wait_done("t1", d0);
        chk_addrs("t1", 3, 29'h100, 29'h108, 29'h110);
        chk("t1_done_after_beat", done_cyc > last_beat_cyc, 1'b1);
        chk("t1_busy_after", busy, 1'b0);

        // Partial final burst issued once.
        d0 = done_cnt;
        iss_q.delete();
        start_xfer(29'h200, 32'd40);
        wait_done("t2", d0);
        cycles(10);
        chk_addrs("t2", 2, 29'h200, 29'h208, 29'h0);

        // Ring wrap.
        wrap_en    = 1'b1;
        ring_base  = 29'h0;
        ring_limit = 29'h20;
        d0 = done_cnt;
        iss_q.delete();
        start_xfer(29'h18, 32'd96);
        wait_done("t3", d0);
        chk_addrs("t3", 3, 29'h18, 29'h0, 29'h8);
        wrap_en = 1'b0;

        // Zero-length transfer.
        d0 = done_cnt;
        iss_q.delete();
        start_xfer(29'h600, 32'd0);
        cycles(3);
        chk("t0_done_pulses", done_cnt - d0, 1);
        chk("t0_nreq", iss_q.size(), 0);
        chk("t0_busy", busy, 1'b0);

        // Credit limit: buffer one below threshold.
        ob_count  = 9'd199;
        return_en = 1'b0;
        d0 = done_cnt;
        iss_q.delete();
        start_xfer(29'h300, 32'd64);
        cycles(12);
        chk_addrs("t4a", 1, 29'h300, 29'h0, 29'h0);
        chk("t4_ost_one", outstanding, 1);
        return_en = 1'b1;
        wait_done("t4", d0);
        chk_addrs("t4b", 2, 29'h300, 29'h308, 29'h0);
        ob_count = '0;

        // Abort with two commands in flight.
        ob_count  = 9'd198;
        return_en = 1'b0;
        iss_q.delete();
        start_xfer(29'h400, 32'd320);
        cycles(10);
        chk("t5_ost_two", outstanding, 2);
        chk_addrs("t5a", 2, 29'h400, 29'h408, 29'h0);
        flushing      = 1'b1;
        readout_done  = 1'b1;
        readout_start = 1'b1;
        @(posedge clk);
        #2;
        readout_done  = 1'b0;
        readout_start = 1'b0;
        ob_count      = '0;
        cycles(10);
        chk("t5_busy_abort", busy, 1'b0);
        start_xfer(29'h500, 32'd32);
        cycles(5);
        chk("t5_nreq_held", iss_q.size(), 2);
        return_en = 1'b1;
        cycles(15);
        chk("t5_ost_drained", outstanding, 0);
        flushing = 1'b0;
        d0 = done_cnt;
        iss_q.delete();
        start_xfer(29'h500, 32'd32);
        wait_done("t5", d0);
        chk_addrs("t5b", 1, 29'h500, 29'h0, 29'h0);

        // Stray data with nothing outstanding.
        stray_req++;
        cycles(3);
        chk("t6_err_set", err_overrun, 1'b1);
        chk("t6_ost_zero", outstanding, 0);
        d0 = done_cnt;
        iss_q.delete();
        start_xfer(29'h700, 32'd32);
        wait_done("t6", d0);
        chk_addrs("t6", 1, 29'h700, 29'h0, 29'h0);
        chk("t6_err_sticky", err_overrun, 1'b1);

        cycles(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ddr_readout_ctrl.md
DDR_READOUT_CTRL -- requirements
Module: ddr_readout_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 256, memory and output-buffer data width in bits.
REQ-002 SHALL have parameter ADDR_W, 29, memory word-address width.
REQ-003 SHALL have parameter BURST_BYTES, 32, bytes returned per accepted read command.
REQ-004 SHALL have parameter ADDR_INC, 8, word-address increment per command.
REQ-005 SHALL have parameter OBCNT_W, 9, width of the output-buffer write-count input.
REQ-006 SHALL have parameter OB_THRESH, 200, credit limit (buffered plus in-flight beats).
REQ-007 SHALL have parameter OST_W, 10, outstanding-counter width.
REQ-008 SHALL have parameter RST_CYC, 4, output-buffer reset pulse length in clk cycles.
REQ-009 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- reset_clk  in  1  reset, asynchronous, active-high.
- readout_start  in  1  start pulse.
- readout_done  in  1  abort/finish, flushes the buffer.
- readout_addr  in  ADDR_W  start word address.
- readout_count  in  32  bytes to read.
- wrap_en  in  1  ring-buffer mode.
- ring_base, ring_limit  in  ADDR_W each  ring region [base, limit).
- mem_rd_req  out  1  read command.
- mem_rd_addr  out  ADDR_W  command address.
- mem_rd_ack  in  1  command accepted.
- mem_rd_data  in  DATA_W  read data.
- mem_rd_data_valid  in  1  read data valid.
- ob_wr_en  out  1  buffer write.
- ob_din  out  DATA_W  buffer data.
- ob_count  in  OBCNT_W  buffer write-side fill.
- ob_rst  out  1  buffer reset.
- ob_wr_rst_busy, ob_rd_rst_busy  in  1 each  buffer reset busy.
- busy  out  1  transfer active.
- done  out  1  one-cycle pulse at transfer completion.
- outstanding  out  OST_W  accepted, not-yet-returned commands.
- err_overrun  out  1  sticky protocol error.

Function
REQ-010 SHALL implement states RST_FIFO, WAIT_RST, IDLE, REQ, DRAIN.
- RST_FIFO: ob_rst=1 for RST_CYC cycles, then WAIT_RST.
- WAIT_RST: go to IDLE when both busy inputs are low and outstanding==0.
REQ-011 IDLE: on readout_start, SHALL load mem_rd_addr=readout_addr and remaining=readout_count, then enter REQ. readout_count==0 SHALL pulse done and stay in IDLE.
REQ-012 REQ: SHALL assert mem_rd_req when remaining>0 and ob_count+outstanding<OB_THRESH.
- Once asserted, mem_rd_req and mem_rd_addr SHALL hold until mem_rd_ack.
REQ-013 On ack:
- remaining SHALL decrease by BURST_BYTES, saturating at 0, so a partial final burst is issued once.
- Address SHALL advance by ADDR_INC. When wrap_en=1 and next>=ring_limit, address SHALL become ring_base.
- A new request MAY assert in the same cycle if REQ-012 holds (back-to-back).
REQ-014 When remaining reaches 0, SHALL enter DRAIN. On outstanding==0, SHALL pulse done one cycle and return to IDLE.
REQ-015 outstanding SHALL +1 on req&&ack and -1 on data_valid. Both in one cycle leaves it unchanged.
REQ-016 data_valid with outstanding==0 SHALL set err_overrun and leave the counter at 0. err_overrun clears only on reset.
REQ-017 ob_wr_en/ob_din SHALL follow mem_rd_data_valid/mem_rd_data with exactly one cycle latency.
- ob_wr_en SHALL be suppressed while in RST_FIFO or WAIT_RST.
REQ-018 readout_done in any state SHALL win over readout_start and go to RST_FIFO with the reset counter cleared.
- Any pending mem_rd_req SHALL stay asserted until acked; no further requests are issued.
REQ-019 readout_start outside IDLE SHALL be ignored.
REQ-020 busy SHALL be high in REQ and DRAIN only.

Reset
REQ-021 reset_clk SHALL asynchronously force:
- state=RST_FIFO, ob_rst=1, reset counter=0.
- mem_rd_req=0, mem_rd_addr=0, remaining=0.
- ob_wr_en=0, ob_din=0.
- outstanding=0, busy=0, done=0, err_overrun=0.

Structure
REQ-022 Package ddr_readout_pkg SHALL hold the state enumeration and default parameter constants.
REQ-023 The outstanding counter with error detection SHALL be sub-module readout_ost_counter.

Verification
REQ-024 Bench SHALL cover:
- Reset release, busy inputs low after 3 cycles -> ob_rst high exactly 4 cycles, then IDLE.
- Start addr=0x100, count=96, ack every cycle -> 3 requests at 0x100/0x108/0x110, done after 3rd data beat.
- count=40 -> exactly 2 requests, remaining ends 0, no underflow.
- wrap_en=1, base=0x0, limit=0x20, addr=0x18, count=96 -> addresses 0x18, 0x0, 0x8.
- ob_count=199, outstanding=0 -> one request issued, none more until ob_count+outstanding<200.
- readout_done mid-transfer with 2 outstanding -> no new requests, data not written, IDLE only after both return. Stray data_valid -> err_overrun=1.
